// File: rtl/instr_mem_bank.sv
// rtl/instr_mem_bank.sv - dual-port instruction memory with fill-on-reset sequencer
module instr_mem_bank #(
  parameter int                DATA_W        = 32,
  parameter int                ADDR_W        = 12,
  parameter int                RD_LATENCY    = 1,
  parameter int                INIT_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_WORD     = DATA_W'(32'h00000013)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic [ADDR_W-1:0]   cpu_addr,
  output logic                cpu_ready,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  input  logic                cpu_lock,
  input  logic                host_we,
  input  logic [DATA_W/8-1:0] host_be,
  input  logic                host_re,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  output logic                host_ready,
  output logic                host_rvalid,
  output logic [DATA_W-1:0]   host_rdata,
  output logic                init_busy
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  typedef enum logic {FILL, RUN} state_t;
  localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? FILL : RUN;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;

  // Shared write port: the fill sequencer owns it during FILL, the host afterwards.
  logic                mem_we;
  logic [NBYTES-1:0]   mem_be;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                cpu_acc, host_racc;
  logic                cpu_v1, host_v1;
  logic [DATA_W-1:0]   cpu_d1, host_d1;

  // Sequencer state and fill address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // Next state, port readiness and write-port steering
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    init_busy  = 1'b0;
    cpu_ready  = 1'b0;
    host_ready = 1'b0;
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_waddr  = host_addr;
    mem_wdata  = host_wdata;
    case (state_q)
      FILL: begin
        init_busy  = 1'b1;
        mem_we     = 1'b1;
        mem_be     = '1;
        mem_waddr  = fill_cnt_q;
        mem_wdata  = INIT_WORD;
        fill_cnt_d = fill_cnt_q + 1'b1;
        if (fill_cnt_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // rst_n gating keeps both ports closed while reset is held in RUN (no-fill mode)
        cpu_ready  = rst_n & ~cpu_lock;
        host_ready = rst_n;
        mem_we     = host_we;
        mem_be     = host_be;
      end
    endcase
  end

  assign cpu_acc   = cpu_req & cpu_ready;
  assign host_racc = host_re & host_ready;

  // Byte-lane write into the array; reads elsewhere see the old word this cycle
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (mem_be[i]) begin
          mem[mem_waddr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
        end
      end
    end
  end

  // First read stage for both ports; data registers hold until the next accepted read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_v1  <= 1'b0;
      cpu_d1  <= '0;
      host_v1 <= 1'b0;
      host_d1 <= '0;
    end else begin
      cpu_v1  <= cpu_acc;
      host_v1 <= host_racc;
      if (cpu_acc) begin
        cpu_d1 <= mem[cpu_addr];
      end
      if (host_racc) begin
        host_d1 <= mem[host_addr];
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic              cpu_v2, host_v2;
      logic [DATA_W-1:0] cpu_d2, host_d2;

      // Optional output register stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cpu_v2  <= 1'b0;
          cpu_d2  <= '0;
          host_v2 <= 1'b0;
          host_d2 <= '0;
        end else begin
          cpu_v2  <= cpu_v1;
          host_v2 <= host_v1;
          if (cpu_v1) begin
            cpu_d2 <= cpu_d1;
          end
          if (host_v1) begin
            host_d2 <= host_d1;
          end
        end
      end

      assign cpu_rvalid  = cpu_v2;
      assign cpu_rdata   = cpu_d2;
      assign host_rvalid = host_v2;
      assign host_rdata  = host_d2;
    end else begin : g_lat1
      assign cpu_rvalid  = cpu_v1;
      assign cpu_rdata   = cpu_d1;
      assign host_rvalid = host_v1;
      assign host_rdata  = host_d1;
    end
  endgenerate

endmodule

// File: tb/tb_instr_mem_bank.sv
// tb/tb_instr_mem_bank.sv - self-checking bench for instr_mem_bank
module tb_instr_mem_bank;
  localparam int AW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: RD_LATENCY=1 with fill; index 1: RD_LATENCY=2 without fill
  logic          rst_n       [2];
  logic          cpu_req     [2];
  logic [AW-1:0] cpu_addr    [2];
  logic          cpu_ready   [2];
  logic          cpu_rvalid  [2];
  logic [DW-1:0] cpu_rdata   [2];
  logic          cpu_lock    [2];
  logic          host_we     [2];
  logic [3:0]    host_be     [2];
  logic          host_re     [2];
  logic [AW-1:0] host_addr   [2];
  logic [DW-1:0] host_wdata  [2];
  logic          host_ready  [2];
  logic          host_rvalid [2];
  logic [DW-1:0] host_rdata  [2];
  logic          init_busy   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    instr_mem_bank #(
      .DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(g + 1),
      .INIT_ON_RESET((g == 0) ? 1 : 0), .INIT_WORD(32'h00000013)
    ) u_dut (
      .clk(clk), .rst_n(rst_n[g]),
      .cpu_req(cpu_req[g]), .cpu_addr(cpu_addr[g]), .cpu_ready(cpu_ready[g]),
      .cpu_rvalid(cpu_rvalid[g]), .cpu_rdata(cpu_rdata[g]), .cpu_lock(cpu_lock[g]),
      .host_we(host_we[g]), .host_be(host_be[g]), .host_re(host_re[g]),
      .host_addr(host_addr[g]), .host_wdata(host_wdata[g]), .host_ready(host_ready[g]),
      .host_rvalid(host_rvalid[g]), .host_rdata(host_rdata[g]), .init_busy(init_busy[g])
    );
  end

  typedef struct {
    int          sec;
    int          d;
    logic        creq;
    logic [3:0]  caddr;
    logic        lock;
    logic        cready;
    logic [31:0] cexp;
    logic        we;
    logic [3:0]  be;
    logic        re;
    logic [3:0]  haddr;
    logic [31:0] wdata;
    logic [31:0] hexp;
  } vec_t;

  typedef struct {
    int          d;
    logic [31:0] exp;
    int          due;
  } sb_t;

  vec_t tbl[$];
  sb_t  cq[$];
  sb_t  hq[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   fill_n;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: each rvalid pulse pops the oldest expectation for that instance
  always @(negedge clk) begin
    sb_t e;
    for (int d = 0; d < 2; d++) begin
      if (cpu_rvalid[d] === 1'b1) begin
        if (cq.size() == 0 || cq[0].d != d) begin
          n_tests++; n_fail++;
          $display("FAIL cpu_rvalid_unexpected: dut %0d got rvalid=1, want 0", d);
        end else begin
          e = cq.pop_front();
          chk("cpu_rdata", cpu_rdata[d], e.exp);
          chk("cpu_latency", cyc, e.due);
        end
      end
      if (host_rvalid[d] === 1'b1) begin
        if (hq.size() == 0 || hq[0].d != d) begin
          n_tests++; n_fail++;
          $display("FAIL host_rvalid_unexpected: dut %0d got rvalid=1, want 0", d);
        end else begin
          e = hq.pop_front();
          chk("host_rdata", host_rdata[d], e.exp);
          chk("host_latency", cyc, e.due);
        end
      end
    end
  end

  function automatic vec_t mk(int sec, int d, logic creq, logic [3:0] caddr, logic lock,
                              logic cready, logic [31:0] cexp, logic we, logic [3:0] be,
                              logic re, logic [3:0] haddr, logic [31:0] wdata, logic [31:0] hexp);
    vec_t v;
    v.sec = sec; v.d = d; v.creq = creq; v.caddr = caddr; v.lock = lock; v.cready = cready;
    v.cexp = cexp; v.we = we; v.be = be; v.re = re; v.haddr = haddr; v.wdata = wdata; v.hexp = hexp;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d);
    cpu_req[d] = 1'b0; cpu_addr[d] = '0; cpu_lock[d] = 1'b0;
    host_we[d] = 1'b0; host_be[d] = '0; host_re[d] = 1'b0;
    host_addr[d] = '0; host_wdata[d] = '0;
  endtask

  // One RUN-mode cycle: drive, check readiness, record expected read results
  task automatic step(input vec_t v);
    int d;
    d = v.d;
    cpu_req[d] = v.creq; cpu_addr[d] = v.caddr; cpu_lock[d] = v.lock;
    host_we[d] = v.we; host_be[d] = v.be; host_re[d] = v.re;
    host_addr[d] = v.haddr; host_wdata[d] = v.wdata;
    @(negedge clk);
    chk("cpu_ready", cpu_ready[d], v.cready);
    chk("host_ready", host_ready[d], 1);
    if (v.creq && v.cready) cq.push_back('{d, v.cexp, cyc + d + 1});
    if (v.re) hq.push_back('{d, v.hexp, cyc + d + 1});
    tick();
    idle(d);
  endtask

  task automatic run_sec(input int s);
    foreach (tbl[i]) begin
      if (tbl[i].sec == s) step(tbl[i]);
    end
  endtask

  // Counts cycles with init_busy high while requests are pressed on both ports
  task automatic count_fill(input int d, output int n);
    n = 0;
    cpu_req[d] = 1'b1; cpu_addr[d] = 4'd5; host_re[d] = 1'b1; host_addr[d] = 4'd5;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (init_busy[d] !== 1'b1) break;
      n++;
      chk("fill_cpu_ready", cpu_ready[d], 0);
      chk("fill_host_ready", host_ready[d], 0);
    end
    idle(d);
    tick();
  endtask

  task automatic check_reset(input int d, input logic busy);
    chk("rst_cpu_rvalid", cpu_rvalid[d], 0);
    chk("rst_host_rvalid", host_rvalid[d], 0);
    chk("rst_cpu_rdata", cpu_rdata[d], 0);
    chk("rst_host_rdata", host_rdata[d], 0);
    chk("rst_cpu_ready", cpu_ready[d], 0);
    chk("rst_host_ready", host_ready[d], 0);
    chk("rst_init_busy", init_busy[d], busy);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time %0t, want finish before 100000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    //              sec d creq caddr lock rdy cexp           we be    re haddr wdata          hexp
    tbl.push_back(mk(0, 0, 1, 4'd5,  0, 1, 32'h00000013, 0, 4'h0, 0, 4'd0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 1, 4'd15, 0, 1, 32'h00000013, 0, 4'h0, 0, 4'd0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0, 4'd0,  0, 1, 32'h0,        1, 4'hF, 0, 4'd3, 32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(0, 0, 0, 4'd0,  0, 1, 32'h0,        1, 4'h1, 0, 4'd3, 32'h000000AA, 32'h0));
    tbl.push_back(mk(0, 0, 0, 4'd0,  0, 1, 32'h0,        0, 4'h0, 1, 4'd3, 32'h0,        32'hDEADBEAA));
    tbl.push_back(mk(0, 0, 0, 4'd0,  0, 1, 32'h0,        1, 4'h0, 0, 4'd3, 32'h12345678, 32'h0));
    tbl.push_back(mk(0, 0, 0, 4'd0,  0, 1, 32'h0,        0, 4'h0, 1, 4'd3, 32'h0,        32'hDEADBEAA));
    tbl.push_back(mk(0, 0, 0, 4'd0,  0, 1, 32'h0,        1, 4'hF, 0, 4'd7, 32'h11111111, 32'h0));
    tbl.push_back(mk(0, 0, 1, 4'd7,  0, 1, 32'h11111111, 1, 4'hF, 0, 4'd7, 32'h22222222, 32'h0));
    tbl.push_back(mk(0, 0, 1, 4'd7,  0, 1, 32'h22222222, 0, 4'h0, 0, 4'd0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0, 4'd0,  0, 1, 32'h0,        1, 4'hF, 1, 4'd9, 32'hABCD0123, 32'h00000013));
    tbl.push_back(mk(0, 0, 0, 4'd0,  0, 1, 32'h0,        0, 4'h0, 1, 4'd9, 32'h0,        32'hABCD0123));
    tbl.push_back(mk(0, 0, 1, 4'd3,  0, 1, 32'hDEADBEAA, 0, 4'h0, 1, 4'd7, 32'h0,        32'h22222222));
    tbl.push_back(mk(0, 0, 1, 4'd9,  0, 1, 32'hABCD0123, 0, 4'h0, 0, 4'd0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 1, 0, 4'd0,  0, 1, 32'h0,        1, 4'hF, 0, 4'd2, 32'hCAFEF00D, 32'h0));
    tbl.push_back(mk(1, 1, 0, 4'd0,  0, 1, 32'h0,        1, 4'hF, 0, 4'd0, 32'h000000A0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 4'd0,  0, 1, 32'h0,        1, 4'hF, 0, 4'd1, 32'h000000A1, 32'h0));
    tbl.push_back(mk(1, 1, 1, 4'd0,  0, 1, 32'h000000A0, 0, 4'h0, 0, 4'd0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 1, 1, 4'd1,  1, 0, 32'h0,        0, 4'h0, 0, 4'd0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 1, 1, 4'd2,  1, 0, 32'h0,        0, 4'h0, 0, 4'd0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 1, 1, 4'd2,  0, 1, 32'hCAFEF00D, 0, 4'h0, 0, 4'd0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 1, 1, 4'd1,  0, 1, 32'h000000A1, 0, 4'h0, 1, 4'd2, 32'h0,        32'hCAFEF00D));
    tbl.push_back(mk(1, 1, 0, 4'd0,  0, 1, 32'h0,        1, 4'h6, 0, 4'd1, 32'h12345678, 32'h0));
    tbl.push_back(mk(1, 1, 0, 4'd0,  0, 1, 32'h0,        0, 4'h0, 1, 4'd1, 32'h0,        32'h003456A1));
    tbl.push_back(mk(2, 1, 1, 4'd2,  0, 1, 32'hCAFEF00D, 0, 4'h0, 1, 4'd0, 32'h0,        32'h000000A0));

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      idle(d);
    end
    repeat (3) tick();
    check_reset(0, 1'b1);
    check_reset(1, 1'b0);

    // Fill after reset, then the RD_LATENCY=1 vectors
    rst_n[0] = 1'b1;
    count_fill(0, fill_n);
    chk("fill_len", fill_n, 16);
    run_sec(0);
    repeat (3) tick();

    // Reset with live output data, then reset again nine cycles into the fill
    rst_n[0] = 1'b0;
    #1;
    check_reset(0, 1'b1);
    tick();
    rst_n[0] = 1'b1;
    repeat (9) tick();
    chk("midfill_busy", init_busy[0], 1);
    rst_n[0] = 1'b0;
    #1;
    check_reset(0, 1'b1);
    tick();
    rst_n[0] = 1'b1;
    count_fill(0, fill_n);
    chk("refill_len", fill_n, 16);
    for (int a = 0; a < 16; a++) begin
      step(mk(9, 0, 1, 4'(a), 0, 1, 32'h00000013, 0, 4'h0, 0, 4'd0, 32'h0, 32'h0));
    end
    repeat (4) tick();
    chk("cpu_rvalid_idle", cpu_rvalid[0], 0);
    chk("cpu_rdata_hold", cpu_rdata[0], 32'h00000013);

    // No-fill instance: ready immediately, lock and latency-2 vectors
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk("noinit_busy", init_busy[1], 0);
    chk("noinit_ready_first", cpu_ready[1], 1);
    tick();
    run_sec(1);
    repeat (4) tick();

    // Contents must survive reset when no fill runs
    rst_n[1] = 1'b0;
    #1;
    check_reset(1, 1'b0);
    tick();
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk("noinit_busy_again", init_busy[1], 0);
    chk("noinit_ready_again", cpu_ready[1], 1);
    tick();
    run_sec(2);
    repeat (5) tick();

    chk("sb_drain", cq.size() + hq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_mem_bank.md
Name: instr_mem_bank

Overview:
Parametrised, initialising instruction memory for the RISC-V core. It is a true dual-port block RAM with two ports:
- CPU fetch port: request/valid handshake, selectable read latency.
- Host (AXI-side) port: byte-enabled word writes and read-back.

After reset, an internal sequencer fills the whole array with a known instruction so the CPU never fetches X. A host-driven lock stalls fetch while a program is loaded.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 12, word-address width; DEPTH = 2**ADDR_W.
- RD_LATENCY, 1, CPU and host read latency in cycles; legal values are 1 or 2.
- INIT_ON_RESET, 1, 1 = run the fill sequence after every reset; 0 = skip it.
- INIT_WORD, 32'h00000013, fill value (RV32I NOP).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  fetch request.
- cpu_addr  in  ADDR_W  fetch word address.
- cpu_ready  out  1  fetch accepted this cycle when high together with cpu_req.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid.
- cpu_rdata  out  DATA_W  fetched word.
- cpu_lock  in  1  host holds the CPU off the memory.
- host_we  in  1  host write strobe.
- host_be  in  DATA_W/8  byte enables for host write.
- host_re  in  1  host read strobe.
- host_addr  in  ADDR_W  host word address, used for both read and write.
- host_wdata  in  DATA_W  host write data.
- host_ready  out  1  host access accepted this cycle.
- host_rvalid  out  1  one-cycle pulse: host_rdata valid.
- host_rdata  out  DATA_W  host read-back word.
- init_busy  out  1  fill sequence in progress.

Behaviour:
- Clocking and reset: single clock domain. rst_n is asynchronous active-low, and all control state clears immediately on assertion.
- Output reset values:
  - cpu_rvalid, host_rvalid = 0.
  - cpu_rdata, host_rdata = 0.
  - init_busy = INIT_ON_RESET.
  - cpu_ready and host_ready = 0 while rst_n is low.
- The memory array is not reset. Contents survive reset only when INIT_ON_RESET = 0.

State machine (states FILL, RUN):
- On reset release, the block enters FILL if INIT_ON_RESET = 1, otherwise RUN.
- FILL:
  - Writes INIT_WORD to address fill_cnt, one word per cycle, starting at fill_cnt = 0.
  - After writing DEPTH-1, moves to RUN; init_busy falls on the cycle RUN is entered.
  - FILL lasts exactly DEPTH cycles.
  - cpu_ready = 0 and host_ready = 0 throughout. Requests made during FILL are not queued.
- Reset asserted mid-FILL restarts the fill from address 0.

CPU port (RUN):
- cpu_ready = ~cpu_lock.
- A fetch is accepted when cpu_req && cpu_ready.
- cpu_rvalid pulses exactly RD_LATENCY cycles after acceptance, with the data at the accepted address.
- Back-to-back accepts give back-to-back rvalid pulses (throughput 1 per cycle).
- RD_LATENCY = 2 adds an output register stage.
- cpu_rdata holds its last value when cpu_rvalid = 0.
- Fetches already accepted before cpu_lock rises still complete.

Host port (RUN):
- host_ready = 1.
- Address and data are sampled in the same cycle as host_we. There is no address pre-latch.
- Write: each byte lane i with host_be[i] = 1 is updated. host_be = 0 writes nothing.
- Read: host_rvalid pulses RD_LATENCY cycles after host_re is accepted.
- host_we and host_re together at the same address: the write is performed and the read returns the OLD word (read-first).

Port collisions:
- Host write and CPU fetch to the same address in the same cycle: the CPU receives the OLD word (read-first). The new word is visible to fetches accepted on the next cycle onward.
- Separate ports: CPU and host accesses never stall each other.

Address handling: addresses are exactly ADDR_W bits with no wrap logic; out-of-range is impossible by construction.

Test Plan:
- Fill after reset (ADDR_W=4, INIT_ON_RESET=1): release rst_n -> init_busy high for exactly 16 cycles, cpu_ready = 0 during that time; then fetch addr 5 and addr 15 -> 0x00000013 each, cpu_rvalid one cycle after accept (RD_LATENCY=1).
- Byte-enabled write: host writes 0xDEADBEEF with be=4'hF to addr 3, then 0x000000AA with be=4'h1 -> host read addr 3 returns 0xDEADBEAA; a write with be=4'h0 leaves 0xDEADBEAA unchanged.
- Collision, read-first: addr 7 holds 0x11111111; in the same cycle, host writes 0x22222222 and CPU fetches addr 7 -> CPU gets 0x11111111; the next fetch gets 0x22222222.
- Lock and latency (RD_LATENCY=2): fetch addrs 0,1,2 back-to-back with cpu_lock rising on the cycle after the first accept -> only addr 0 accepted, rvalid 2 cycles later; cpu_ready is 0 until cpu_lock falls, then accepts resume.
- Reset mid-fill: assert rst_n low at fill cycle 9, release -> init_busy high a full 16 cycles again, all words = 0x00000013, rvalid/rdata outputs 0 during reset.
- INIT_ON_RESET=0: write 0xCAFEF00D to addr 2, pulse reset -> init_busy stays 0, cpu_ready is 1 on the first cycle after release, and fetch addr 2 returns 0xCAFEF00D.
